// File: rtl/ffo_pkg.sv
// Shared types and helpers for the ffo_normalize sequential left-normalizer.
package ffo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } ffo_state_e;

   // Selects the top 2**stage bits of a width-bit word, LSB-aligned in 32 bits.
   function automatic logic [31:0] top_step_mask(input int width, input int stage);
      logic [31:0] mask;
      mask = '0;
      for (int i = 0; i < 32; i++) begin
         if ((i < width) && (i >= width - (1 << stage))) begin
            mask[i] = 1'b1;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/ffo_normalize.sv
// Left-normalizer: binary-search shift of the operand until its leading one
// reaches the MSB, one search stage per clock, with valid/ready on both sides.
module ffo_normalize
   import ffo_pkg::*;
#(
   parameter  int N     = 32,
   localparam int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_data,
   output logic [IDX_W-1:0] out_index,
   output logic             out_zero
);

   ffo_state_e       state_q, state_d;
   logic [N-1:0]     data_q, data_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] stage_q, stage_d;
   logic             zero_q, zero_d;

   logic [31:0]      mask_full;
   logic [IDX_W-1:0] step;
   logic             top_clear;

   always_comb begin
      mask_full = top_step_mask(N, int'(stage_q));
      step      = IDX_W'(1) << stage_q;
      top_clear = ((data_q & mask_full[N-1:0]) == '0);
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               data_d  = in_data;
               cnt_d   = '0;
               stage_d = IDX_W'(IDX_W - 1);
               zero_d  = (in_data == '0);
               state_d = (in_data == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            // An empty top window means the leading one lies further down.
            if (top_clear) begin
               data_d = data_q << step;
               cnt_d  = cnt_q + step;
            end
            if (stage_q == '0) begin
               state_d = DONE;
            end else begin
               stage_d = stage_q - IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         stage_q <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         zero_q  <= zero_d;
      end
   end

   // Result fields are forced to zero whenever no result is being offered.
   always_comb begin
      in_ready  = resetN && (state_q == IDLE);
      out_valid = (state_q == DONE);
      out_data  = '0;
      out_index = '0;
      out_zero  = 1'b0;
      if (state_q == DONE) begin
         out_data  = data_q;
         out_index = zero_q ? '0 : (IDX_W'(N - 1) - cnt_q);
         out_zero  = zero_q;
      end
   end

endmodule

// File: tb/tb_ffo_normalize.sv
// Scoreboard bench for ffo_normalize, cross-checked against a FindFirstOne model.
module tb_ffo_normalize;
   import ffo_pkg::*;

   localparam int N     = 32;
   localparam int IDX_W = $clog2(N);

   typedef struct {
      logic [N-1:0]     data;
      logic [IDX_W-1:0] index;
      logic             zero;
      int               latency;
   } exp_t;

   exp_t scoreboard[$];

   logic             clk       = 1'b0;
   logic             resetN    = 1'b0;
   logic             in_valid  = 1'b0;
   logic             out_ready = 1'b0;
   logic [N-1:0]     in_data   = '0;
   logic             in_ready;
   logic             out_valid;
   logic [N-1:0]     out_data;
   logic [IDX_W-1:0] out_index;
   logic             out_zero;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   ffo_normalize #(.N(N)) dut (
      .clk       (clk),
      .resetN    (resetN),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_zero  (out_zero)
   );

   function automatic int findFirstOne(input logic [N-1:0] v);
      for (int i = N - 1; i >= 0; i--) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   // Latency counts clock edges after the acceptance edge; zero operands skip SHIFT.
   function automatic exp_t makeExpected(input logic [N-1:0] v);
      exp_t e;
      int   idx;
      idx       = findFirstOne(v);
      e.zero    = (v == '0);
      e.index   = IDX_W'(idx);
      e.data    = e.zero ? '0 : (v << (N - 1 - idx));
      e.latency = e.zero ? 0 : IDX_W;
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] v);
      int waitCycles;
      waitCycles = 0;
      while (!in_ready && waitCycles < 20) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("in_ready", 32'(in_ready), 32'd1);
      scoreboard.push_back(makeExpected(v));
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic waitValid(output int lat);
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic compareFront(input int lat);
      exp_t e;
      checkOutput("sb_size", 32'(scoreboard.size()), 32'd1);
      checkOutput("out_valid", 32'(out_valid), 32'd1);
      if (scoreboard.size() > 0) begin
         e = scoreboard.pop_front();
         checkOutput("out_data", out_data, e.data);
         checkOutput("out_index", 32'(out_index), 32'(e.index));
         checkOutput("out_zero", 32'(out_zero), 32'(e.zero));
         checkOutput("latency", 32'(lat), 32'(e.latency));
      end
   endtask

   task automatic collectResult();
      int lat;
      waitValid(lat);
      compareFront(lat);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   initial begin
      logic [N-1:0]     heldData;
      logic [IDX_W-1:0] heldIndex;
      logic             heldZero;
      logic             sawValid;
      logic [N-1:0]     walk;
      int               lat;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", out_data, 32'd0);
      checkOutput("rst_out_index", 32'(out_index), 32'd0);
      checkOutput("rst_out_zero", 32'(out_zero), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      resetN = 1'b1;
      #1 checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

      applyStimulus(32'h0000_0001); collectResult();
      applyStimulus(32'h8000_0000); collectResult();
      applyStimulus(32'h0001_2345); collectResult();
      applyStimulus(32'h0000_0000); collectResult();

      // Backpressure: result held while a new operand waits on in_valid.
      applyStimulus(32'h00F0_0000);
      waitValid(lat);
      compareFront(lat);
      heldData  = out_data;
      heldIndex = out_index;
      heldZero  = out_zero;
      in_valid  = 1'b1;
      in_data   = 32'h0000_0300;
      scoreboard.push_back(makeExpected(32'h0000_0300));
      repeat (10) begin
         @(negedge clk);
         checkOutput("bp_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_data", out_data, heldData);
         checkOutput("bp_index", 32'(out_index), 32'(heldIndex));
         checkOutput("bp_zero", 32'(out_zero), 32'(heldZero));
         checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      checkOutput("bp_consumed", 32'(out_valid), 32'd0);
      checkOutput("bp_idle_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      checkOutput("bp_next_accept", 32'(in_ready), 32'd0);
      collectResult();

      // Reset in the third SHIFT cycle discards the operation.
      applyStimulus(32'h0000_1234);
      @(posedge clk);
      @(posedge clk);
      #1 resetN = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
      checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_data", out_data, 32'd0);
      checkOutput("mid_rst_index", 32'(out_index), 32'd0);
      checkOutput("mid_rst_zero", 32'(out_zero), 32'd0);
      checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
      scoreboard.delete();
      @(negedge clk);
      resetN   = 1'b1;
      sawValid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) sawValid = 1'b1;
      end
      checkOutput("no_result_after_rst", 32'(sawValid), 32'd0);

      for (int i = 0; i < N; i++) begin
         walk = '0;
         walk[i] = 1'b1;
         applyStimulus(walk);
         collectResult();
      end

      for (int i = 0; i < 10000; i++) begin
         applyStimulus($urandom >> $urandom_range(0, 31));
         collectResult();
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
